// File: rtl/mean_seq_ctrl.sv
// Sequencing controller for the sample-mean datapath: start/ready/done handshake,
// accumulator/counter enables, fixed-latency divider enable and a stall watchdog.
module mean_seq_ctrl #(
    parameter int DIV_LAT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       data_valid,
    input  logic       co,
    output logic       ready,
    output logic       clear,
    output logic       en_reg,
    output logic       en_cnt,
    output logic       en_div,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    // Handshake: a block is accepted on a rising edge where ready and start are both
    // high; start at any other time is dropped, never queued. done is a one-cycle pulse.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_WAIT = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  LAT_LAST  = 8'(DIV_LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] wdog;
    logic [7:0]  lat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Both counters sit at zero outside their own state, so entry always starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog <= '0;
            lat  <= '0;
        end else begin
            if (abort || state != S_WAIT || data_valid) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 16'd1;
            end
            if (abort || state != S_DIV) begin
                lat <= '0;
            end else begin
                lat <= lat + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_next = S_INIT;
                S_INIT: state_next = S_WAIT;
                S_WAIT: begin
                    // The final sample wins over a watchdog expiry in the same cycle.
                    if (data_valid && co) begin
                        state_next = S_DIV;
                    end else if (!data_valid && wdog == WDOG_LAST) begin
                        state_next = S_ERR;
                    end
                end
                S_DIV:  if (lat == LAT_LAST) state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                S_ERR:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready  = 1'b0;
        clear  = 1'b0;
        en_div = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_INIT: clear = 1'b1;
            S_DIV:  en_div = 1'b1;
            S_DONE: done = 1'b1;
            S_ERR: begin
                err   = 1'b1;
                clear = 1'b1;
            end
            default: ;
        endcase
        en_reg = (state == S_WAIT) && data_valid;
        en_cnt = (state == S_WAIT) && data_valid;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mean_seq_ctrl.sv
// Bench for mean_seq_ctrl: per-cycle vector table, directed block sequences and
// randomized blocks checked against timing derived arithmetically from the block rules.
module tb_mean_seq_ctrl;

    localparam int DIV_LAT = 4;
    localparam int TIMEOUT = 64;
    localparam int BUDGET  = 400;
    localparam int RAND_BLOCKS = 40;

    localparam logic [6:0] R  = 7'b1000000;
    localparam logic [6:0] C  = 7'b0100000;
    localparam logic [6:0] E  = 7'b0011000;
    localparam logic [6:0] D  = 7'b0000100;
    localparam logic [6:0] DN = 7'b0000010;
    localparam logic [6:0] Z  = 7'b0000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic data_valid = 1'b0;
    logic co = 1'b0;
    logic ready, clear, en_reg, en_cnt, en_div, done, err;
    logic [2:0] state_dbg;
    logic [6:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    bit pat_dv[$];
    bit pat_co[$];
    int t_done, t_err, t_ready, n_cnt, n_reg, n_div, n_clr, n_done;

    typedef struct {
        logic       start;
        logic       abort;
        logic       dv;
        logic       co;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl[25];

    always #5 clk = ~clk;

    assign outs = {ready, clear, en_reg, en_cnt, en_div, done, err};

    mean_seq_ctrl #(.DIV_LAT(DIV_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .data_valid(data_valid), .co(co),
        .ready(ready), .clear(clear), .en_reg(en_reg), .en_cnt(en_cnt),
        .en_div(en_div), .done(done), .err(err), .state_dbg(state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sample(input int gap, input bit last, input bit noise);
        for (int j = 0; j < gap; j++) begin
            pat_dv.push_back(1'b0);
            pat_co.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        pat_dv.push_back(1'b1);
        pat_co.push_back(last);
    endtask

    // Cycle 0 is the IDLE cycle carrying start; the pattern begins in cycle 2.
    task automatic drive_block(input bit init_dv, input int abort_cyc);
        int k;
        bit fin;
        k = 0;
        fin = 1'b0;
        t_done = -1; t_err = -1; t_ready = -1;
        n_cnt = 0; n_reg = 0; n_div = 0; n_clr = 0; n_done = 0;
        while (!fin && k < BUDGET) begin
            start = (k == 0);
            abort = (k == abort_cyc);
            if (k == 1) begin
                data_valid = init_dv;
                co = 1'b0;
            end else if (k >= 2 && k - 2 < pat_dv.size()) begin
                data_valid = pat_dv[k-2];
                co = pat_co[k-2];
            end else begin
                data_valid = 1'b0;
                co = 1'b0;
            end
            @(negedge clk);
            if (k == 0) check("block_start_ready", ready, 1);
            if (done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
            if (err && t_err < 0) t_err = k;
            n_cnt += int'(en_cnt);
            n_reg += int'(en_reg);
            n_div += int'(en_div);
            n_clr += int'(clear);
            if (k > 0 && ready) begin
                t_ready = k;
                fin = 1'b1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0; abort = 1'b0; data_valid = 1'b0; co = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL block_budget: got no ready within %0d cycles expected ready", BUDGET);
        end
    endtask

    initial begin
        // Reset and first-start acceptance
        #2;
        check("rst_outputs", outs, R);
        @(negedge clk);
        check("rst_held_outputs", outs, R);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("first_start_clear", outs, C);
        @(posedge clk);
        #1;
        data_valid = 1'b1;
        @(posedge clk);
        #3;
        check("pre_rst_en_reg", en_reg, 1);
        rst = 1'b0;
        #1;
        check("async_rst_mid_block", outs, R);
        check("async_rst_state", state_dbg, 0);
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Per-cycle vector table
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, R};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, R};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, C};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, E};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, Z};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, E};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, D};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, D};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, R};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, R};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, R};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, C};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, R};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, C};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, E};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, D};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, D};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, D};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, D};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, DN};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, R};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, R};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, C};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, Z};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, R};
        for (int i = 0; i < 25; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            data_valid = tbl[i].dv;
            co = tbl[i].co;
            @(negedge clk);
            check($sformatf("table_row_%0d", i), outs, tbl[i].exp);
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; data_valid = 1'b0; co = 1'b0;

        // Nominal block: N=8 back-to-back
        pat_dv.delete(); pat_co.delete();
        for (int i = 0; i < 8; i++) push_sample(0, i == 7, 1'b0);
        drive_block(1'b0, -1);
        check("nom_done_t", t_done, 14);
        check("nom_ready_t", t_ready, 15);
        check("nom_en_cnt", n_cnt, 8);
        check("nom_en_reg", n_reg, 8);
        check("nom_en_div", n_div, DIV_LAT);
        check("nom_clear", n_clr, 1);
        check("nom_done_n", n_done, 1);

        // Gapped block: 3-cycle gaps between samples, co noise in gaps
        pat_dv.delete(); pat_co.delete();
        for (int i = 0; i < 8; i++) push_sample(i == 0 ? 0 : 3, i == 7, 1'b1);
        drive_block(1'b1, -1);
        check("gap_done_t", t_done, 35);
        check("gap_en_cnt", n_cnt, 8);
        check("gap_err_t", t_err, -1);

        // Watchdog: 2 samples then silence
        pat_dv.delete(); pat_co.delete();
        push_sample(0, 1'b0, 1'b0);
        push_sample(0, 1'b0, 1'b0);
        drive_block(1'b0, -1);
        check("wd_err_t", t_err, 3 + TIMEOUT + 1);
        check("wd_ready_t", t_ready, 3 + TIMEOUT + 2);
        check("wd_done_n", n_done, 0);
        check("wd_clear", n_clr, 2);
        check("wd_en_cnt", n_cnt, 2);

        // Abort in the 2nd DIV cycle, then a normal block
        pat_dv.delete(); pat_co.delete();
        for (int i = 0; i < 8; i++) push_sample(0, i == 7, 1'b0);
        drive_block(1'b0, 11);
        check("abort_en_div", n_div, 2);
        check("abort_done_n", n_done, 0);
        check("abort_err_t", t_err, -1);
        check("abort_ready_t", t_ready, 12);
        pat_dv.delete(); pat_co.delete();
        for (int i = 0; i < 2; i++) push_sample(0, i == 1, 1'b0);
        drive_block(1'b0, -1);
        check("post_abort_done_t", t_done, 2 + DIV_LAT + 2);

        // Final sample coincides with watchdog expiry
        pat_dv.delete(); pat_co.delete();
        push_sample(0, 1'b0, 1'b0);
        push_sample(TIMEOUT - 1, 1'b1, 1'b0);
        drive_block(1'b0, -1);
        check("simul_err_t", t_err, -1);
        check("simul_done_t", t_done, 2 + TIMEOUT + DIV_LAT + 1);

        // Randomized blocks against arithmetic timing
        for (int b = 0; b < RAND_BLOCKS; b++) begin
            int n, cyc, e_done, e_err, e_ready, e_cnt, e_div, e_clr, g, r;
            bit erred;
            n = $urandom_range(1, 10);
            cyc = 2; e_done = -1; e_err = -1; e_ready = -1;
            e_cnt = 0; e_div = 0; e_clr = 1; erred = 1'b0;
            pat_dv.delete(); pat_co.delete();
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                if (r < 10) g = 0;
                else if (r < 15) g = $urandom_range(1, 5);
                else if (r < 17) g = TIMEOUT - 1;
                else if (r < 19) g = TIMEOUT - 2;
                else g = TIMEOUT + $urandom_range(0, 3);
                push_sample(g, i == n - 1, 1'b1);
                if (!erred) begin
                    if (g >= TIMEOUT) begin
                        erred = 1'b1;
                        e_err = cyc + TIMEOUT;
                        e_ready = e_err + 1;
                        e_clr = 2;
                    end else begin
                        cyc += g + 1;
                        e_cnt++;
                    end
                end
            end
            if (!erred) begin
                e_done = cyc + DIV_LAT;
                e_ready = e_done + 1;
                e_div = DIV_LAT;
            end
            drive_block(1'($urandom_range(0, 1)), -1);
            check($sformatf("rnd%0d_done_t", b), t_done, e_done);
            check($sformatf("rnd%0d_err_t", b), t_err, e_err);
            check($sformatf("rnd%0d_ready_t", b), t_ready, e_ready);
            check($sformatf("rnd%0d_en_cnt", b), n_cnt, e_cnt);
            check($sformatf("rnd%0d_en_div", b), n_div, e_div);
            check($sformatf("rnd%0d_clear", b), n_clr, e_clr);
        end

        // start held high: blocks repeat every N+DIV_LAT+3 cycles (N=3)
        begin
            int dcount;
            int dq[$];
            dcount = 0;
            start = 1'b1;
            data_valid = 1'b1;
            for (int k = 0; k < 45; k++) begin
                co = (dcount == 2);
                @(negedge clk);
                if (done) dq.push_back(k);
                if (clear) dcount = 0;
                else if (en_cnt) dcount++;
                @(posedge clk);
                #1;
            end
            start = 1'b0; data_valid = 1'b0; co = 1'b0;
            check("held_done_count_ge3", dq.size() >= 3, 1);
            if (dq.size() >= 3) begin
                check("held_period_1", dq[1] - dq[0], 3 + DIV_LAT + 3);
                check("held_period_2", dq[2] - dq[1], 3 + DIV_LAT + 3);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
